// File: rtl/gpio_mon_pkg.sv
// Shared types and helpers for the GPIO signature monitor: FSM encoding,
// default MISR constants and the data-to-signature fold.
package gpio_mon_pkg;

  typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, TOUT} mon_state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;
  localparam int unsigned FOLD_MAX = 64;

  // XOR data bit i into result bit i % sw; buses wider than sw wrap around.
  function automatic logic [FOLD_MAX-1:0] fold(input logic [FOLD_MAX-1:0] data,
                                               input int unsigned        dw,
                                               input int unsigned        sw);
    logic [FOLD_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FOLD_MAX; i++) begin
      if (i < dw) r[i % sw] = r[i % sw] ^ data[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_mon_fifo.sv
// Synchronous show-ahead log FIFO with flush; a push on full is accepted
// only when a pop frees a slot in the same cycle.
module gpio_mon_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (do_pop) rd_d = rd_q + (AW+1)'(1);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/gpio_signature_monitor.sv
// Self-judging GPIO activity monitor: synchronises a masked bus, compresses
// each change into a MISR, logs timestamped changes and flags PASS/FAIL/TIMEOUT.
module gpio_signature_monitor
  import gpio_mon_pkg::*;
#(
  parameter int unsigned      WIDTH = 34,
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
  parameter int unsigned      CNT_W = 16,
  parameter int unsigned      TO_W  = 24,
  parameter int unsigned      TS_W  = 16,
  parameter int unsigned      DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      mask,
  input  logic [WIDTH-1:0]      gpio_in,
  input  logic [CNT_W-1:0]      exp_changes,
  input  logic [SIG_W-1:0]      exp_sig,
  input  logic [TO_W-1:0]       timeout_lim,
  input  logic                  fifo_rd,
  output logic [TS_W+WIDTH-1:0] fifo_rdata,
  output logic                  fifo_empty,
  output logic                  overflow,
  output logic [CNT_W-1:0]      change_cnt,
  output logic [SIG_W-1:0]      signature,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout
);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_next;
  logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic             tout_q, tout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] masked;
  logic             chg, push, flush, fifo_full;

  always_comb begin
    masked   = s2_q & mask;
    chg      = |((s2_q ^ prev_q) & mask);
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    sig_next = (sig_q << 1) ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(fold(FOLD_MAX'(masked), WIDTH, SIG_W));

    state_d = state_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    ts_d    = ts_q;
    idle_d  = idle_q;
    sig_d   = sig_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tout_d  = tout_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    flush   = 1'b0;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      ts_d    = '0;
      idle_d  = '0;
      sig_d   = SEED;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      tout_d  = 1'b0;
      ovf_d   = 1'b0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE, TOUT: begin
          if (start) begin
            state_d = ARM;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            tout_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        ARM: begin
          prev_d = s2_q;
          cnt_d  = '0;
          ts_d   = '0;
          idle_d = '0;
          sig_d  = SEED;
          flush  = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
          fail_d = 1'b0;
          tout_d = 1'b0;
          ovf_d  = 1'b0;
          if (exp_changes == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (SEED == exp_sig);
            fail_d  = (SEED != exp_sig);
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          ts_d = ts_q + TS_W'(1);
          // A change in the same cycle as the timeout threshold resets idle instead.
          if (chg) begin
            prev_d = s2_q;
            cnt_d  = cnt_inc;
            idle_d = '0;
            sig_d  = sig_next;
            push   = 1'b1;
            if (cnt_inc == exp_changes) begin
              state_d = DONE;
              done_d  = 1'b1;
              pass_d  = (sig_next == exp_sig);
              fail_d  = (sig_next != exp_sig);
            end
          end else begin
            idle_d = idle_q + TO_W'(1);
            if ((timeout_lim != '0) && (idle_d == timeout_lim)) begin
              state_d = TOUT;
              tout_d  = 1'b1;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (push && fifo_full && !fifo_rd) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
      idle_q  <= '0;
      sig_q   <= SEED;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= gpio_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      idle_q  <= idle_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tout_q  <= tout_d;
      ovf_q   <= ovf_d;
    end
  end

  gpio_mon_fifo #(
    .DEPTH (DEPTH),
    .DW    (TS_W + WIDTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .flush (flush),
    .push  (push),
    .wdata ({ts_q, masked}),
    .pop   (fifo_rd),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign busy       = (state_q == ARM) || (state_q == RUN);
  assign change_cnt = cnt_q;
  assign signature  = sig_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = tout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_gpio_signature_monitor.sv
// Directed bench for gpio_signature_monitor in an 8-bit configuration with
// hand-computed MISR values (POLY 8'h1D, SEED 8'hFF).
module tb_gpio_signature_monitor;

  logic        clk = 1'b0;
  logic        nrst, start, clear, fifo_rd;
  logic [7:0]  mask, gpio_in, exp_sig, signature;
  logic [15:0] exp_changes, change_cnt;
  logic [23:0] timeout_lim, fifo_rdata;
  logic        fifo_empty, overflow, busy, done, pass, fail, timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_signature_monitor #(
    .WIDTH (8),
    .SIG_W (8),
    .POLY  (8'h1D),
    .SEED  (8'hFF),
    .CNT_W (16),
    .TO_W  (24),
    .TS_W  (16),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .clear       (clear),
    .mask        (mask),
    .gpio_in     (gpio_in),
    .exp_changes (exp_changes),
    .exp_sig     (exp_sig),
    .timeout_lim (timeout_lim),
    .fifo_rd     (fifo_rd),
    .fifo_rdata  (fifo_rdata),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .change_cnt  (change_cnt),
    .signature   (signature),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pop();
    fifo_rd = 1'b1;
    step(1);
    fifo_rd = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; clear = 1'b0; fifo_rd = 1'b0;
    mask = 8'hFF; gpio_in = 8'h00; exp_changes = 16'd0; exp_sig = 8'h00;
    timeout_lim = 24'd0;
    step(2);

    // Power-on reset state
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_tout", timeout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", change_cnt, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_sig", signature, 8'hFF);
    nrst = 1'b1;
    step(3);

    // Async reset in the middle of a run
    exp_changes = 16'd5;
    pulse_start();
    gpio_in = 8'h01;
    step(4);
    chk("mid_cnt", change_cnt, 1);
    chk("mid_sig", signature, 8'hE2);
    chk("mid_busy", busy, 1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_sig", signature, 8'hFF);
    chk("arst_cnt", change_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_empty", fifo_empty, 1);
    chk("arst_done", done, 0);
    step(1);
    nrst = 1'b1;
    gpio_in = 8'h00;
    step(3);

    // Golden run: 01, 03, 07 at 5-cycle spacing -> signature AE
    exp_changes = 16'd3;
    exp_sig = 8'hAE;
    pulse_start();
    chk("arm_busy", busy, 1);
    gpio_in = 8'h01; step(5);
    gpio_in = 8'h03; step(5);
    gpio_in = 8'h07; step(2);
    chk("gold_early", done, 0);
    step(1);
    chk("gold_done", done, 1);
    chk("gold_pass", pass, 1);
    chk("gold_fail", fail, 0);
    chk("gold_cnt", change_cnt, 3);
    chk("gold_sig", signature, 8'hAE);
    chk("gold_busy", busy, 0);
    chk("log0", fifo_rdata, 24'h0001_01);
    pop();
    chk("log1", fifo_rdata, 24'h0006_03);
    pop();
    chk("log2", fifo_rdata, 24'h000B_07);
    pop();
    chk("log_empty", fifo_empty, 1);
    pop();
    chk("pop_on_empty", fifo_empty, 1);

    // Mask: bit 7 excluded, bit 0 counted
    gpio_in = 8'h00;
    pulse_clear();
    step(3);
    mask = 8'h0F;
    exp_changes = 16'd5;
    pulse_start();
    gpio_in = 8'h80; step(4);
    chk("mask_cnt0", change_cnt, 0);
    chk("mask_empty", fifo_empty, 1);
    gpio_in = 8'h81; step(3);
    chk("mask_cnt1", change_cnt, 1);
    chk("mask_push", fifo_empty, 0);
    chk("mask_data", fifo_rdata & 24'h0000FF, 24'h000001);
    pulse_start();
    step(2);
    chk("start_in_run_cnt", change_cnt, 1);
    chk("start_in_run_busy", busy, 1);

    // Inactivity timeout at 20 idle cycles
    gpio_in = 8'h00;
    pulse_clear();
    step(3);
    mask = 8'hFF;
    timeout_lim = 24'd20;
    pulse_start();
    step(20);
    chk("tout_early", timeout, 0);
    step(1);
    chk("tout_flag", timeout, 1);
    chk("tout_fail", fail, 1);
    chk("tout_done", done, 1);
    chk("tout_pass", pass, 0);
    chk("tout_busy", busy, 0);
    pulse_start();
    step(18);
    gpio_in = 8'h01;
    step(3);
    chk("tout_saved", timeout, 0);
    chk("tout_saved_cnt", change_cnt, 1);
    chk("tout_saved_busy", busy, 1);

    // Overflow: 6 changes into a 4-deep log, no reads -> signature 35
    gpio_in = 8'h00;
    pulse_clear();
    step(3);
    timeout_lim = 24'd0;
    exp_changes = 16'd6;
    exp_sig = 8'h35;
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      gpio_in = 8'(i);
      step(2);
    end
    step(2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", change_cnt, 6);
    chk("ovf_pass", pass, 1);
    chk("ovf_sig", signature, 8'h35);
    for (int j = 1; j <= 4; j++) begin
      chk("ovf_order", fifo_rdata & 24'h0000FF, 32'(j));
      pop();
    end
    chk("ovf_drained", fifo_empty, 1);

    // Same traffic with a read on each push, wrong expected signature
    gpio_in = 8'h00;
    pulse_clear();
    step(3);
    exp_sig = 8'h00;
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      gpio_in = 8'(i);
      fifo_rd = 1'b1;
      step(1);
      fifo_rd = 1'b0;
      step(1);
    end
    step(3);
    chk("rd_ovf", overflow, 0);
    chk("rd_fail", fail, 1);
    chk("rd_pass", pass, 0);
    chk("rd_sig", signature, 8'h35);
    chk("rd_head", fifo_rdata & 24'h0000FF, 24'h000005);
    chk("rd_nonempty", fifo_empty, 0);

    // exp_changes == 0 resolves straight out of ARM
    gpio_in = 8'h00;
    pulse_clear();
    step(1);
    exp_changes = 16'd0;
    exp_sig = 8'hFF;
    pulse_start();
    chk("zero_arm_busy", busy, 1);
    chk("zero_arm_done", done, 0);
    step(1);
    chk("zero_done", done, 1);
    chk("zero_pass", pass, 1);
    chk("zero_fail", fail, 0);

    // clear beats start
    clear = 1'b1;
    start = 1'b1;
    step(1);
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", busy, 0);
    chk("clr_start_done", done, 0);
    step(1);
    chk("clr_start_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
